// File: rtl/centroid_update_divider_if.sv
// Bundle between the accumulate stage, the centroid update divider and the
// centroid memory consumer. The master side requests a pass and supplies the
// accumulators and counts; the slave side (the divider) returns one centroid
// per cent_valid strobe.
interface centroid_update_divider_if #(
    parameter int centroid_num     = 8,
    parameter int coord_num        = 7,
    parameter int accum_cord_width = 22,
    parameter int cordinate_width  = 13,
    parameter int count_width      = 10,
    parameter int accum_width      = coord_num * accum_cord_width
);
    logic                                   start;
    logic [centroid_num*accum_width-1:0]    accum_all;
    logic [centroid_num*count_width-1:0]    cnt_all;
    logic                                   busy;
    logic                                   cent_valid;
    logic [$clog2(centroid_num)-1:0]        cent_idx;
    logic [coord_num*cordinate_width-1:0]   cent_data;
    logic                                   cent_empty;
    logic                                   div_ovf;
    logic                                   done;

    modport master (
        output start, accum_all, cnt_all,
        input  busy, cent_valid, cent_idx, cent_data, cent_empty, div_ovf, done
    );

    modport slave (
        input  start, accum_all, cnt_all,
        output busy, cent_valid, cent_idx, cent_data, cent_empty, div_ovf, done
    );
endinterface

// File: rtl/centroid_update_divider.sv
// Centroid update divider: after a classification pass, divides every
// coordinate accumulator of every centroid by that centroid's point count
// using one shared radix-2 restoring divider, and emits each new centroid
// (truncated, saturated to the output coordinate width) as a single strobe.
module centroid_update_divider #(
    parameter int centroid_num     = 8,
    parameter int coord_num        = 7,
    parameter int accum_cord_width = 22,
    parameter int cordinate_width  = 13,
    parameter int count_width      = 10,
    parameter int accum_width      = coord_num * accum_cord_width
) (
    input  logic                      clk,
    input  logic                      rst,
    centroid_update_divider_if.slave  bus
);

    localparam int idx_w   = $clog2(centroid_num);
    localparam int coord_w = $clog2(coord_num);
    localparam int bit_w   = $clog2(accum_cord_width);
    localparam int rem_w   = count_width + 1;
    localparam int data_w  = coord_num * cordinate_width;

    localparam logic [idx_w-1:0]           last_c   = idx_w'(centroid_num - 1);
    localparam logic [coord_w-1:0]         last_i   = coord_w'(coord_num - 1);
    localparam logic [bit_w-1:0]           last_bit = bit_w'(accum_cord_width - 1);
    localparam logic [cordinate_width-1:0] q_max    = '1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD,
        DIV,
        STORE,
        EMIT,
        DONE
    } state_t;

    state_t                      state;
    logic [idx_w-1:0]            c_idx;
    logic [coord_w-1:0]          i_idx;
    logic [accum_cord_width-1:0] dividend;
    logic [count_width-1:0]      divisor;
    logic [rem_w-1:0]            rem;
    logic [accum_cord_width-1:0] quot;
    logic [bit_w-1:0]            bit_cnt;
    logic [data_w-1:0]           coord_reg;

    logic                        busy_r;
    logic                        valid_r;
    logic [idx_w-1:0]            idx_r;
    logic [data_w-1:0]           data_r;
    logic                        empty_r;
    logic                        ovf_r;
    logic                        done_r;

    logic [count_width-1:0]      cur_count;
    logic [accum_cord_width-1:0] cur_accum;
    logic [rem_w-1:0]            rem_shift;
    logic                        rem_fits;
    logic                        q_sat;
    logic [cordinate_width-1:0]  q_out;
    logic [data_w-1:0]           merged;

    // Operand selection, one restoring step, and saturation/merge of the finished quotient.
    always_comb begin
        cur_count = bus.cnt_all[int'(c_idx)*count_width +: count_width];
        cur_accum = bus.accum_all[int'(c_idx)*accum_width + int'(i_idx)*accum_cord_width +: accum_cord_width];
        rem_shift = {rem[rem_w-2:0], dividend[accum_cord_width-1]};
        rem_fits  = (rem_shift >= {1'b0, divisor});
        q_sat     = |quot[accum_cord_width-1:cordinate_width];
        q_out     = q_sat ? q_max : quot[cordinate_width-1:0];
        merged    = coord_reg;
        merged[int'(i_idx)*cordinate_width +: cordinate_width] = q_out;
    end

    // Pass sequencer and divider datapath with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            c_idx     <= '0;
            i_idx     <= '0;
            dividend  <= '0;
            divisor   <= '0;
            rem       <= '0;
            quot      <= '0;
            bit_cnt   <= '0;
            coord_reg <= '0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            idx_r     <= '0;
            data_r    <= '0;
            empty_r   <= 1'b0;
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= CHECK;
                        c_idx  <= '0;
                        i_idx  <= '0;
                        ovf_r  <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                CHECK: begin
                    if (cur_count == '0) begin
                        state   <= EMIT;
                        valid_r <= 1'b1;
                        idx_r   <= c_idx;
                        data_r  <= '0;
                        empty_r <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    dividend <= cur_accum;
                    divisor  <= cur_count;
                    rem      <= '0;
                    quot     <= '0;
                    bit_cnt  <= last_bit;
                    state    <= DIV;
                end
                DIV: begin
                    dividend <= dividend << 1;
                    rem      <= rem_fits ? (rem_shift - {1'b0, divisor}) : rem_shift;
                    quot     <= {quot[accum_cord_width-2:0], rem_fits};
                    if (bit_cnt == '0) begin
                        state <= STORE;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STORE: begin
                    coord_reg <= merged;
                    if (q_sat) begin
                        ovf_r <= 1'b1;
                    end
                    if (i_idx == last_i) begin
                        state   <= EMIT;
                        valid_r <= 1'b1;
                        idx_r   <= c_idx;
                        data_r  <= merged;
                        empty_r <= 1'b0;
                    end else begin
                        i_idx <= i_idx + 1'b1;
                        state <= LOAD;
                    end
                end
                EMIT: begin
                    valid_r <= 1'b0;
                    i_idx   <= '0;
                    if (c_idx == last_c) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        c_idx <= c_idx + 1'b1;
                        state <= CHECK;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.cent_valid = valid_r;
    assign bus.cent_idx   = idx_r;
    assign bus.cent_data  = data_r;
    assign bus.cent_empty = empty_r;
    assign bus.div_ovf    = ovf_r;
    assign bus.done       = done_r;

endmodule
